// File: rtl/seq_detector_param_pkg.sv
// Shared types and limits for the parametrised serial pattern detector.
package seq_detector_param_pkg;

    // Detector FSM: FILL while history is still loading, ARMED once a full window exists
    typedef enum logic {
        ST_FILL  = 1'b0,
        ST_ARMED = 1'b1
    } state_e;

    // Legal pattern lengths
    localparam int PAT_W_MIN = 2;
    localparam int PAT_W_MAX = 16;

endpackage

// File: rtl/seq_detector_param_sat_counter.sv
// Saturating event counter with sticky saturation flag and synchronous clear.
module sat_counter #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             inc,
    input  logic             clr,
    output logic [CNT_W-1:0] cnt,
    output logic             sat
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             sat_q, sat_d;

    // Next count: clear wins, otherwise increment until the maximum is reached
    always_comb begin
        cnt_d = cnt_q;
        sat_d = sat_q;
        if (clr) begin
            cnt_d = '0;
            sat_d = 1'b0;
        end else if (inc && (cnt_q != CNT_MAX)) begin
            cnt_d = cnt_q + 1'b1;
            if (cnt_d == CNT_MAX) sat_d = 1'b1;
        end
    end

    // Count and flag registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_q <= '0;
            sat_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            sat_q <= sat_d;
        end
    end

    assign cnt = cnt_q;
    assign sat = sat_q;

endmodule

// File: rtl/seq_detector_param.sv
// Serial pattern detector with run-time loadable pattern, overlap select and match counter.
module seq_detector_param
    import seq_detector_param_pkg::*;
#(
    parameter int PAT_W = 4,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic             I,
    input  logic             cfg_load,
    input  logic [PAT_W-1:0] pattern,
    input  logic             overlap,
    input  logic             clr_cnt,
    output logic             O,
    output logic [CNT_W-1:0] match_cnt,
    output logic             sat
);

    // History holds the PAT_W-1 bits preceding the current one; fill counts up to PAT_W-1
    localparam int HW = PAT_W - 1;
    localparam int FW = $clog2(PAT_W);

    logic [PAT_W-1:0] pat_q, pat_d;
    logic             ovl_q, ovl_d;
    logic [HW-1:0]    hist_q, hist_d;
    logic [FW-1:0]    fill_q, fill_d;
    state_e           state_q, state_d;
    logic             o_q, o_d;
    logic             match;

    // Config capture, history shift, fill tracking and match decision
    always_comb begin
        pat_d   = pat_q;
        ovl_d   = ovl_q;
        hist_d  = hist_q;
        fill_d  = fill_q;
        state_d = state_q;
        match   = 1'b0;
        if (cfg_load) begin
            // New config flushes history; the bit on I this cycle is dropped
            pat_d   = pattern;
            ovl_d   = overlap;
            hist_d  = '0;
            fill_d  = '0;
            state_d = ST_FILL;
        end else if (en) begin
            hist_d = HW'({hist_q, I});
            if (fill_q != FW'(HW)) fill_d = fill_q + 1'b1;
            case (state_q)
                ST_FILL: begin
                    if (fill_q == FW'(PAT_W - 2)) state_d = ST_ARMED;
                end
                ST_ARMED: begin
                    match = ({hist_q, I} == pat_q);
                    // Non-overlap: the matched bits must not seed the next match
                    if (match && !ovl_q) begin
                        hist_d  = '0;
                        fill_d  = '0;
                        state_d = ST_FILL;
                    end
                end
                default: state_d = ST_FILL;
            endcase
        end
        o_d = match;
    end

    // Detector state registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pat_q   <= '0;
            ovl_q   <= 1'b1;
            hist_q  <= '0;
            fill_q  <= '0;
            state_q <= ST_FILL;
            o_q     <= 1'b0;
        end else begin
            pat_q   <= pat_d;
            ovl_q   <= ovl_d;
            hist_q  <= hist_d;
            fill_q  <= fill_d;
            state_q <= state_d;
            o_q     <= o_d;
        end
    end

    assign O = o_q;

    sat_counter #(
        .CNT_W (CNT_W)
    ) u_cnt (
        .clk   (clk),
        .reset (reset),
        .inc   (match),
        .clr   (clr_cnt),
        .cnt   (match_cnt),
        .sat   (sat)
    );

endmodule

// File: tb/tb_seq_detector_param.sv
// Directed bench: two detectors share stimulus, one with an 8-bit and one with a 2-bit counter.
module tb_seq_detector_param;

    logic       clk = 1'b0;
    logic       reset, en, I, cfg_load, overlap, clr_cnt;
    logic [3:0] pattern;
    logic       o_a, sat_a, o_b, sat_b;
    logic [7:0] cnt_a;
    logic [1:0] cnt_b;

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    seq_detector_param #(.PAT_W(4), .CNT_W(8)) dut_a (
        .clk(clk), .reset(reset), .en(en), .I(I), .cfg_load(cfg_load),
        .pattern(pattern), .overlap(overlap), .clr_cnt(clr_cnt),
        .O(o_a), .match_cnt(cnt_a), .sat(sat_a)
    );

    seq_detector_param #(.PAT_W(4), .CNT_W(2)) dut_b (
        .clk(clk), .reset(reset), .en(en), .I(I), .cfg_load(cfg_load),
        .pattern(pattern), .overlap(overlap), .clr_cnt(clr_cnt),
        .O(o_b), .match_cnt(cnt_b), .sat(sat_b)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Apply one clock with en/I, then check O just after the edge
    task automatic step(input logic e, input logic b, input logic exp_o, input string tag);
        en = e;
        I  = b;
        @(posedge clk);
        #1;
        chk(tag, {31'b0, o_a}, {31'b0, exp_o});
        en = 1'b0;
    endtask

    // Load pattern/overlap and clear the counters in the same cycle
    task automatic cfg(input logic [3:0] p, input logic ovl);
        cfg_load = 1'b1;
        clr_cnt  = 1'b1;
        pattern  = p;
        overlap  = ovl;
        en       = 1'b1;
        I        = 1'b1;
        @(posedge clk);
        #1;
        cfg_load = 1'b0;
        clr_cnt  = 1'b0;
        en       = 1'b0;
        chk("cfg_o", {31'b0, o_a}, 32'd0);
        chk("cfg_cnt", {24'b0, cnt_a}, 32'd0);
    endtask

    initial begin
        reset = 1'b0; en = 1'b0; I = 1'b0; cfg_load = 1'b0;
        overlap = 1'b0; clr_cnt = 1'b0; pattern = 4'b0000;
        #12;
        chk("rst_o", {31'b0, o_a}, 32'd0);
        chk("rst_cnt", {24'b0, cnt_a}, 32'd0);
        chk("rst_sat", {31'b0, sat_a}, 32'd0);
        reset = 1'b1;
        @(posedge clk); #1;

        // 1: overlapping, 1101 in 1,1,0,1,1,0,1
        cfg(4'b1101, 1'b1);
        step(1, 1, 0, "t1_b1"); step(1, 1, 0, "t1_b2"); step(1, 0, 0, "t1_b3");
        step(1, 1, 1, "t1_b4"); step(1, 1, 0, "t1_b5"); step(1, 0, 0, "t1_b6");
        step(1, 1, 1, "t1_b7");
        step(0, 0, 0, "t1_idle");
        chk("t1_cnt", {24'b0, cnt_a}, 32'd2);

        // 2: non-overlapping, same stream
        cfg(4'b1101, 1'b0);
        step(1, 1, 0, "t2_b1"); step(1, 1, 0, "t2_b2"); step(1, 0, 0, "t2_b3");
        step(1, 1, 1, "t2_b4"); step(1, 1, 0, "t2_b5"); step(1, 0, 0, "t2_b6");
        step(1, 1, 0, "t2_b7");
        chk("t2_cnt", {24'b0, cnt_a}, 32'd1);

        // 3: idle cycles with toggling I are ignored
        cfg(4'b1101, 1'b1);
        step(1, 1, 0, "t3_b1"); step(1, 1, 0, "t3_b2");
        step(0, 0, 0, "t3_i1"); step(0, 1, 0, "t3_i2"); step(0, 0, 0, "t3_i3");
        step(1, 0, 0, "t3_b3"); step(1, 1, 1, "t3_b4");
        step(1, 0, 0, "t3_b5");
        chk("t3_cnt", {24'b0, cnt_a}, 32'd1);

        // 4: reload mid-stream flushes history and drops the I bit of that cycle
        cfg(4'b1101, 1'b1);
        step(1, 1, 0, "t4_b1"); step(1, 1, 0, "t4_b2"); step(1, 0, 0, "t4_b3");
        cfg(4'b0110, 1'b1);
        step(1, 1, 0, "t4_c1"); step(1, 0, 0, "t4_c2"); step(1, 1, 0, "t4_c3");
        step(1, 1, 0, "t4_c4"); step(1, 0, 1, "t4_c5");
        chk("t4_cnt", {24'b0, cnt_a}, 32'd1);

        // 5: all-ones overlap gives back-to-back matches; 2-bit counter saturates
        cfg(4'b1111, 1'b1);
        step(1, 1, 0, "t5_b1"); step(1, 1, 0, "t5_b2"); step(1, 1, 0, "t5_b3");
        step(1, 1, 1, "t5_b4"); step(1, 1, 1, "t5_b5"); step(1, 1, 1, "t5_b6");
        step(1, 1, 1, "t5_b7"); step(1, 1, 1, "t5_b8");
        chk("t5_cnt_b", {30'b0, cnt_b}, 32'd3);
        chk("t5_sat_b", {31'b0, sat_b}, 32'd1);
        chk("t5_cnt_a", {24'b0, cnt_a}, 32'd5);
        chk("t5_sat_a", {31'b0, sat_a}, 32'd0);
        chk("t5_o_b", {31'b0, o_b}, 32'd1);
        clr_cnt = 1'b1;
        step(1, 1, 1, "t5_clr_o");
        clr_cnt = 1'b0;
        chk("t5_clr_cnt_b", {30'b0, cnt_b}, 32'd0);
        chk("t5_clr_sat_b", {31'b0, sat_b}, 32'd0);
        chk("t5_clr_cnt_a", {24'b0, cnt_a}, 32'd0);

        // 6: asynchronous reset between edges, then a short stream after release
        cfg(4'b1101, 1'b1);
        step(1, 1, 0, "t6_b1"); step(1, 1, 0, "t6_b2"); step(1, 0, 0, "t6_b3");
        step(1, 1, 1, "t6_b4");
        chk("t6_pre_cnt", {24'b0, cnt_a}, 32'd1);
        #2 reset = 1'b0;
        #1;
        chk("t6_rst_o", {31'b0, o_a}, 32'd0);
        chk("t6_rst_cnt", {24'b0, cnt_a}, 32'd0);
        chk("t6_rst_sat_b", {31'b0, sat_b}, 32'd0);
        @(posedge clk); #1;
        reset = 1'b1;
        step(1, 1, 0, "t6_r1"); step(1, 0, 0, "t6_r2"); step(1, 1, 0, "t6_r3");
        step(1, 0, 0, "t6_r4");
        chk("t6_cnt", {24'b0, cnt_a}, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
